// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC commutation blocks: gate-bus step
// patterns, fault codes, monitor states and small decode helpers.
package bldc_pkg;

  // Gate bus layout: [5:3] high-side A,B,C; [2:0] low-side A,B,C
  localparam logic [5:0] PAT_OFF   = 6'b000_000;
  localparam logic [5:0] PAT_STEP0 = 6'b100_010;
  localparam logic [5:0] PAT_STEP1 = 6'b100_001;
  localparam logic [5:0] PAT_STEP2 = 6'b010_001;
  localparam logic [5:0] PAT_STEP3 = 6'b010_100;
  localparam logic [5:0] PAT_STEP4 = 6'b001_100;
  localparam logic [5:0] PAT_STEP5 = 6'b001_010;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_SHOOT   = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL = 2'b10;
  localparam logic [1:0] FLT_SKIP    = 2'b11;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_FIRST = 2'd1,
    MON_RUN   = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] step;
  } step_dec_t;

  // Map a gate pattern to its commutation step; legal=0 for OFF and illegal
  function automatic step_dec_t decode_step(input logic [5:0] pat);
    step_dec_t d;
    d.legal = 1'b1;
    d.step  = 3'd0;
    case (pat)
      PAT_STEP0: d.step = 3'd0;
      PAT_STEP1: d.step = 3'd1;
      PAT_STEP2: d.step = 3'd2;
      PAT_STEP3: d.step = 3'd3;
      PAT_STEP4: d.step = 3'd4;
      PAT_STEP5: d.step = 3'd5;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Any phase with both its high and low switch on
  function automatic logic shoot_through(input logic [5:0] pat);
    return |(pat[5:3] & pat[2:0]);
  endfunction

  // (nxt - prv) mod 6 for steps in 0..5
  function automatic logic [2:0] step_delta(input logic [2:0] nxt,
                                            input logic [2:0] prv);
    logic [2:0] d;
    if (nxt >= prv) d = nxt - prv;
    else            d = 3'(nxt + 3'd6 - prv);
    return d;
  endfunction

endpackage

// File: rtl/commutation_monitor_pattern_filter.sv
// Gate-bus glitch filter: registers the bus, counts how long the sampled
// value has held, and strobes accept once it has held FILTER_CYCLES samples
// and differs from the last accepted pattern.
module pattern_filter #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] mosfet_in,
  output logic [5:0] sample,
  output logic       accept
);

  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  logic [5:0]       mosfet_s;
  logic [5:0]       accepted;
  logic [CNT_W-1:0] stable_cnt;

  // Counter tracks the run length of the value now in mosfet_s, so it
  // restarts at 1 in the same edge a new value is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosfet_s   <= '0;
      accepted   <= '0;
      stable_cnt <= '0;
    end else begin
      mosfet_s <= mosfet_in;
      if (mosfet_in != mosfet_s)  stable_cnt <= CNT_W'(1);
      else if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CNT_W'(1);
      if (accept) accepted <= mosfet_s;
    end
  end

  assign accept = (stable_cnt == CNT_MAX) && (mosfet_s != accepted);
  assign sample = mosfet_s;

endmodule

// File: rtl/commutation_monitor.sv
// Passive monitor of the 6-bit gate bus: decodes step, direction and
// period, counts steps, and flags shoot-through, illegal patterns, skipped
// steps and stalls.
module commutation_monitor
  import bldc_pkg::*;
#(
  parameter int unsigned         FILTER_CYCLES = 4,
  parameter int unsigned         PERIOD_W      = 16,
  parameter logic [PERIOD_W-1:0] STALL_CYCLES  = 16'd50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          mosfet_in,
  input  logic                fault_clear,
  output logic [2:0]          step,
  output logic                step_valid,
  output logic                dir,
  output logic                dir_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [15:0]         step_count,
  output logic                stall,
  output logic                fault,
  output logic [1:0]          fault_code
);

  logic [5:0] mosfet_s;
  logic       accept;

  pattern_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .mosfet_in (mosfet_in),
    .sample    (mosfet_s),
    .accept    (accept)
  );

  mon_state_t          state_q, state_n;
  logic [2:0]          step_q, step_n;
  logic                step_valid_q, step_valid_n;
  logic                dir_q, dir_n;
  logic                dir_valid_q, dir_valid_n;
  logic [PERIOD_W-1:0] period_q, period_n;
  logic                period_valid_q, period_valid_n;
  logic [15:0]         count_q, count_n;
  logic                stall_q, stall_n;
  logic [PERIOD_W-1:0] timer_q, timer_n;
  logic                fault_q, fault_n;
  logic [1:0]          code_q, code_n;

  logic [PERIOD_W-1:0] timer_inc;
  step_dec_t           dec;
  logic [2:0]          delta;
  logic                shoot_hit, illegal_hit, skip_hit;
  logic [1:0]          new_code;

  assign dec   = decode_step(mosfet_s);
  assign delta = step_delta(dec.step, step_q);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= MON_IDLE;
      step_q         <= '0;
      step_valid_q   <= 1'b0;
      dir_q          <= 1'b0;
      dir_valid_q    <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      count_q        <= '0;
      stall_q        <= 1'b0;
      timer_q        <= '0;
      fault_q        <= 1'b0;
      code_q         <= FLT_NONE;
    end else begin
      state_q        <= state_n;
      step_q         <= step_n;
      step_valid_q   <= step_valid_n;
      dir_q          <= dir_n;
      dir_valid_q    <= dir_valid_n;
      period_q       <= period_n;
      period_valid_q <= period_valid_n;
      count_q        <= count_n;
      stall_q        <= stall_n;
      timer_q        <= timer_n;
      fault_q        <= fault_n;
      code_q         <= code_n;
    end
  end

  // Next-state: classify accepted patterns, run FSM, timer and fault latch
  always_comb begin
    state_n        = state_q;
    step_n         = step_q;
    step_valid_n   = step_valid_q;
    dir_n          = dir_q;
    dir_valid_n    = dir_valid_q;
    period_n       = period_q;
    period_valid_n = 1'b0;
    count_n        = count_q;
    stall_n        = stall_q;
    fault_n        = fault_q;
    code_n         = code_q;
    shoot_hit      = shoot_through(mosfet_s);
    illegal_hit    = 1'b0;
    skip_hit       = 1'b0;
    new_code       = FLT_NONE;

    timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    timer_n   = (state_q == MON_IDLE) ? '0 : timer_inc;

    if (state_q != MON_IDLE && timer_inc == STALL_CYCLES) begin
      stall_n = 1'b1;
      state_n = MON_FIRST;
    end

    if (accept) begin
      if (mosfet_s == PAT_OFF) begin
        state_n     = MON_IDLE;
        step_valid_n = 1'b0;
        dir_valid_n = 1'b0;
        stall_n     = 1'b0;
        timer_n     = '0;
      end else if (!dec.legal) begin
        step_valid_n = 1'b0;
        illegal_hit  = !shoot_hit;
      end else begin
        step_n       = dec.step;
        step_valid_n = 1'b1;
        if (state_q == MON_IDLE) begin
          state_n = MON_FIRST;
          timer_n = '0;
          stall_n = 1'b0;
        end else if (delta == 3'd1 || delta == 3'd5) begin
          // Period counts edges between accepts, hence the incremented timer
          dir_n       = (delta == 3'd5);
          dir_valid_n = 1'b1;
          count_n     = count_q + 16'd1;
          timer_n     = '0;
          stall_n     = 1'b0;
          if (state_q == MON_RUN) begin
            period_n       = timer_inc;
            period_valid_n = 1'b1;
          end
          state_n = MON_RUN;
        end else if (delta != 3'd0) begin
          skip_hit    = 1'b1;
          state_n     = MON_FIRST;
          dir_valid_n = 1'b0;
          timer_n     = '0;
          stall_n     = 1'b0;
        end
      end
    end

    if (shoot_hit)        new_code = FLT_SHOOT;
    else if (illegal_hit) new_code = FLT_ILLEGAL;
    else if (skip_hit)    new_code = FLT_SKIP;

    if (new_code != FLT_NONE && (!fault_q || fault_clear)) begin
      fault_n = 1'b1;
      code_n  = new_code;
    end else if (fault_clear) begin
      fault_n = 1'b0;
      code_n  = FLT_NONE;
    end
  end

  assign step         = step_q;
  assign step_valid   = step_valid_q;
  assign dir          = dir_q;
  assign dir_valid    = dir_valid_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign step_count   = count_q;
  assign stall        = stall_q;
  assign fault        = fault_q;
  assign fault_code   = code_q;

endmodule

// File: tb/tb_commutation_monitor.sv
// Scoreboard bench for commutation_monitor: stimulus pushes expected status
// changes and period pulses with the cycle they should appear; a monitor
// thread pops and compares whenever the DUT outputs change.
module tb_commutation_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fault_clear = 1'b0;
  logic [5:0]  mosfet_in = '0;
  logic [2:0]  step;
  logic        step_valid, dir, dir_valid, period_valid, stall, fault;
  logic [15:0] period, step_count;
  logic [1:0]  fault_code;

  commutation_monitor #(
    .FILTER_CYCLES (4),
    .PERIOD_W      (16),
    .STALL_CYCLES  (16'd50000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mosfet_in    (mosfet_in),
    .fault_clear  (fault_clear),
    .step         (step),
    .step_valid   (step_valid),
    .dir          (dir),
    .dir_valid    (dir_valid),
    .period       (period),
    .period_valid (period_valid),
    .step_count   (step_count),
    .stall        (stall),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]  step;
    logic        sv;
    logic        dir;
    logic        dv;
    logic [15:0] cnt;
    logic        stall;
    logic        fault;
    logic [1:0]  code;
  } st_t;

  typedef struct { st_t st; int cyc; } exp_st_t;
  typedef struct { logic [15:0] val; int cyc; } exp_p_t;

  exp_st_t     sq[$];
  exp_p_t      pq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t_drv = 0;
  int          t_s1 = 0;
  logic        mon_en = 1'b0;
  st_t         prev_st;
  logic        prev_pv;
  logic [5:0]  pats [6];

  function automatic string fmt(input st_t s);
    return $sformatf("step=%0d sv=%0d dir=%0d dv=%0d cnt=%0d stall=%0d fault=%0d code=%0d",
                     s.step, s.sv, s.dir, s.dv, s.cnt, s.stall, s.fault, s.code);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] p);
    mosfet_in = p;
    t_drv = cyc;
  endtask

  task automatic exp_st(input int lat, input logic [2:0] s, input logic sv,
                        input logic d, input logic dv, input logic [15:0] c,
                        input logic stl, input logic f, input logic [1:0] code);
    exp_st_t e;
    e.st.step = s;  e.st.sv = sv;     e.st.dir = d;   e.st.dv = dv;
    e.st.cnt = c;   e.st.stall = stl; e.st.fault = f; e.st.code = code;
    e.cyc = t_drv + lat;
    sq.push_back(e);
  endtask

  task automatic exp_per(input int lat, input logic [15:0] v);
    exp_p_t e;
    e.val = v;
    e.cyc = t_drv + lat;
    pq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic mon_sample();
    st_t     cur;
    exp_st_t e;
    exp_p_t  p;
    cur.step = step;       cur.sv = step_valid; cur.dir = dir;     cur.dv = dir_valid;
    cur.cnt = step_count;  cur.stall = stall;   cur.fault = fault; cur.code = fault_code;
    if (cur !== prev_st) begin
      n_cmp++;
      if (sq.size() == 0) begin
        n_bad++;
        $display("FAIL status_unexpected: got %s at cycle %0d, required no change", fmt(cur), cyc);
      end else begin
        e = sq.pop_front();
        if (cur !== e.st || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL status: got %s at cycle %0d, required %s at cycle %0d",
                   fmt(cur), cyc, fmt(e.st), e.cyc);
        end
      end
      prev_st = cur;
    end
    if (period_valid === 1'b1 && prev_pv !== 1'b1) begin
      n_cmp++;
      if (pq.size() == 0) begin
        n_bad++;
        $display("FAIL period_unexpected: got period=%0d at cycle %0d, required no pulse", period, cyc);
      end else begin
        p = pq.pop_front();
        if (period !== p.val || cyc != p.cyc) begin
          n_bad++;
          $display("FAIL period: got %0d at cycle %0d, required %0d at cycle %0d",
                   period, cyc, p.val, p.cyc);
        end
      end
    end
    if (prev_pv === 1'b1) begin
      n_cmp++;
      if (period_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL period_pulse_width: got period_valid=%0d at cycle %0d, required 0", period_valid, cyc);
      end
    end
    prev_pv = period_valid;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_step"},       32'(step), 0);
    check({tag, "_step_valid"}, 32'(step_valid), 0);
    check({tag, "_dir"},        32'(dir), 0);
    check({tag, "_dir_valid"},  32'(dir_valid), 0);
    check({tag, "_period"},     32'(period), 0);
    check({tag, "_period_vld"}, 32'(period_valid), 0);
    check({tag, "_step_count"}, 32'(step_count), 0);
    check({tag, "_stall"},      32'(stall), 0);
    check({tag, "_fault"},      32'(fault), 0);
    check({tag, "_fault_code"}, 32'(fault_code), 0);
  endtask

  int p2s [5] = '{1, 2, 3, 2, 1};
  logic p2d [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    pats[0] = 6'b100_010; pats[1] = 6'b100_001; pats[2] = 6'b010_001;
    pats[3] = 6'b010_100; pats[4] = 6'b001_100; pats[5] = 6'b001_010;

    fork
      forever begin
        @(negedge clk);
        if (mon_en) mon_sample();
      end
    join_none

    // Reset state
    tick(3);
    check_all_zero("reset");
    prev_st = '0;
    prev_pv = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    tick(5);

    // Forward rotation 0..5,0 at 1000 clocks each
    for (int i = 0; i < 7; i++) begin
      drive(pats[i % 6]);
      exp_st(5, 3'(i % 6), 1'b1, 1'b0, i > 0, 16'(i), 1'b0, 1'b0, 2'b00);
      if (i >= 2) exp_per(5, 16'd1000);
      tick(1000);
    end

    // 1,2,3 then reverse 2,1 at 500 clocks each
    for (int i = 0; i < 5; i++) begin
      drive(pats[p2s[i]]);
      if (i == 4) t_s1 = t_drv;
      exp_st(5, 3'(p2s[i]), 1'b1, p2d[i], 1'b1, 16'(7 + i), 1'b0, 1'b0, 2'b00);
      exp_per(5, (i == 0) ? 16'd1000 : 16'd500);
      tick(500);
    end

    // One-clock shoot-through glitch inside step 1, then clear
    drive(6'b100_100);
    exp_st(2, 3'd1, 1'b1, 1'b1, 1'b1, 16'd11, 1'b0, 1'b1, 2'b01);
    tick(1);
    drive(pats[1]);
    tick(20);
    t_drv = cyc;
    exp_st(1, 3'd1, 1'b1, 1'b1, 1'b1, 16'd11, 1'b0, 1'b0, 2'b00);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    tick(20);

    // Illegal pattern: 3 clocks filtered out, 4 clocks accepted
    drive(6'b110_000);
    tick(3);
    drive(pats[1]);
    tick(20);
    drive(6'b110_000);
    exp_st(5, 3'd1, 1'b0, 1'b1, 1'b1, 16'd11, 1'b0, 1'b1, 2'b10);
    tick(4);
    drive(pats[1]);
    exp_st(5, 3'd1, 1'b1, 1'b1, 1'b1, 16'd11, 1'b0, 1'b1, 2'b10);
    tick(20);
    t_drv = cyc;
    exp_st(1, 3'd1, 1'b1, 1'b1, 1'b1, 16'd11, 1'b0, 1'b0, 2'b00);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    tick(20);

    // Step 0 (adjacent, reversed) then step 2 (skip)
    drive(pats[0]);
    exp_st(5, 3'd0, 1'b1, 1'b1, 1'b1, 16'd12, 1'b0, 1'b0, 2'b00);
    exp_per(5, 16'(t_drv - t_s1));
    tick(500);
    drive(pats[2]);
    exp_st(5, 3'd2, 1'b1, 1'b1, 1'b0, 16'd12, 1'b0, 1'b1, 2'b11);
    tick(100);
    t_drv = cyc;
    exp_st(1, 3'd2, 1'b1, 1'b1, 1'b0, 16'd12, 1'b0, 1'b0, 2'b00);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    tick(20);

    // Re-enter RUN, then hold step 4 past the stall limit
    drive(pats[3]);
    exp_st(5, 3'd3, 1'b1, 1'b0, 1'b1, 16'd13, 1'b0, 1'b0, 2'b00);
    tick(500);
    drive(pats[4]);
    exp_st(5, 3'd4, 1'b1, 1'b0, 1'b1, 16'd14, 1'b0, 1'b0, 2'b00);
    exp_per(5, 16'd500);
    exp_st(5 + 50000, 3'd4, 1'b1, 1'b0, 1'b1, 16'd14, 1'b1, 1'b0, 2'b00);
    tick(50010);
    drive(pats[5]);
    exp_st(5, 3'd5, 1'b1, 1'b0, 1'b1, 16'd15, 1'b0, 1'b0, 2'b00);
    tick(100);

    // OFF, restart from IDLE, then async reset mid-run
    drive(6'b000_000);
    exp_st(5, 3'd5, 1'b0, 1'b0, 1'b0, 16'd15, 1'b0, 1'b0, 2'b00);
    tick(50);
    drive(pats[0]);
    exp_st(5, 3'd0, 1'b1, 1'b0, 1'b0, 16'd15, 1'b0, 1'b0, 2'b00);
    tick(300);
    drive(pats[1]);
    exp_st(5, 3'd1, 1'b1, 1'b0, 1'b1, 16'd16, 1'b0, 1'b0, 2'b00);
    tick(200);
    t_drv = cyc;
    exp_st(0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    mosfet_in = '0;
    #1;
    check_all_zero("async_rst");
    tick(3);
    rst = 1'b0;
    tick(10);

    check("status_queue_drained", 32'(sq.size()), 0);
    check("period_queue_drained", 32'(pq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
